// File: rtl/pipelined_decode_stage.sv
// MIPS decode stage: bypassed register file, immediate generation, load-use hazard
// detection and the ID/EX pipeline register with valid/stall/flush control.
module pipelined_decode_stage #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter bit          ZERO_REG  = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [31:0]       instr,
   input  logic              stall_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_rd,
   output logic              id_ready,
   output logic              hazard_stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_immed,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic [5:0]        out_opcode,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [5:0] OpRType = 6'b100000;

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              wb_commit;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_gen;
   logic [DATA_W-1:0] regs_q [REG_COUNT];

   assign opcode   = instr[31:26];
   assign a_addr   = instr[21 +: ADDR_W];
   assign wr_addr  = instr[16 +: ADDR_W];
   assign b_addr   = (opcode == OpRType) ? instr[11 +: ADDR_W] : instr[16 +: ADDR_W];
   assign imm_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

   // Writes to the hard-wired zero register are dropped here so the bypass ignores them too.
   assign wb_commit = wb_en && !(ZERO_REG && (wb_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_commit) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rd_a = regs_q[a_addr];
      if (wb_commit && (wb_addr == a_addr)) rd_a = wb_data;
      if (ZERO_REG && (a_addr == '0)) rd_a = '0;
   end

   always_comb begin
      rd_b = regs_q[b_addr];
      if (wb_commit && (wb_addr == b_addr)) rd_b = wb_data;
      if (ZERO_REG && (b_addr == '0)) rd_b = '0;
   end

   always_comb begin
      imm_gen = imm_sext;
      casez (opcode)
         6'b111111, 6'b00000?: imm_gen = imm_sext << 2;
         6'b111001: begin
            imm_gen        = '0;
            imm_gen[31:16] = instr[15:0];
         end
         6'b11001?: imm_gen = {{(DATA_W-16){1'b0}}, instr[15:0]};
         default: ;
      endcase
   end

   assign hazard_stall = in_valid && ex_is_load && (ex_rd != '0) &&
                         ((ex_rd == a_addr) || (ex_rd == b_addr));
   assign id_ready     = !stall_in && !hazard_stall;

   // Flush outranks stall and hazard; data fields keep their old values on a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_a       <= '0;
         out_b       <= '0;
         out_immed   <= '0;
         out_wr_addr <= '0;
         out_opcode  <= '0;
         stall_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (stall_in) begin
         out_valid <= out_valid;
      end else if (hazard_stall) begin
         out_valid <= 1'b0;
         if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
      end else begin
         out_valid   <= in_valid;
         out_a       <= rd_a;
         out_b       <= rd_b;
         out_immed   <= imm_gen;
         out_wr_addr <= wr_addr;
         out_opcode  <= opcode;
      end
   end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: expected ID/EX contents are queued as each
// instruction is driven and popped after the clock edge; a 2-bit counter copy checks saturation.
module tb_pipelined_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall_in, flush, wb_en, ex_is_load;
   logic [31:0] instr, wb_data;
   logic [4:0]  wb_addr, ex_rd;

   logic        id_ready, hazard_stall, out_valid;
   logic [31:0] out_a, out_b, out_immed;
   logic [4:0]  out_wr_addr;
   logic [5:0]  out_opcode;
   logic [15:0] stall_count;

   logic        s_id_ready, s_hazard_stall, s_out_valid;
   logic [31:0] s_out_a, s_out_b, s_out_immed;
   logic [4:0]  s_out_wr_addr;
   logic [5:0]  s_out_opcode;
   logic [1:0]  s_stall_count;

   always #5 clk = ~clk;

   pipelined_decode_stage u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .stall_in(stall_in),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_ready(id_ready),
      .hazard_stall(hazard_stall), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
      .out_immed(out_immed), .out_wr_addr(out_wr_addr), .out_opcode(out_opcode),
      .stall_count(stall_count)
   );

   pipelined_decode_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .stall_in(stall_in),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_ready(s_id_ready),
      .hazard_stall(s_hazard_stall), .out_valid(s_out_valid), .out_a(s_out_a),
      .out_b(s_out_b), .out_immed(s_out_immed), .out_wr_addr(s_out_wr_addr),
      .out_opcode(s_out_opcode), .stall_count(s_stall_count)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  wr;
      logic [5:0]  op;
      logic [15:0] cnt;
      logic [1:0]  cnts;
   } exp_t;

   exp_t        sb[$];
   exp_t        last;
   logic [15:0] cnt_m;
   logic [1:0]  cnt_s;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
      return {6'b100000, rs, rt, rd, 11'b0};
   endfunction

   task automatic idle();
      rst = 1'b0; in_valid = 1'b0; instr = '0; stall_in = 1'b0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_is_load = 1'b0; ex_rd = '0;
   endtask

   task automatic expect_load(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] wr,
                              input logic [5:0] op);
      exp_t e;
      e.v = v; e.a = a; e.b = b; e.imm = imm; e.wr = wr; e.op = op;
      e.cnt = cnt_m; e.cnts = cnt_s;
      sb.push_back(e);
   endtask

   task automatic expect_hold(input logic v, input logic inc);
      exp_t e;
      if (inc) begin
         cnt_m = cnt_m + 16'd1;
         if (cnt_s != 2'd3) cnt_s = cnt_s + 2'd1;
      end
      e = last;
      e.v = v; e.cnt = cnt_m; e.cnts = cnt_s;
      sb.push_back(e);
   endtask

   task automatic expect_reset();
      cnt_m = '0;
      cnt_s = '0;
      sb.push_back('0);
   endtask

   task automatic comb_chk(input string tag, input logic haz, input logic rdy);
      #1;
      chk({tag, ".hazard"}, 32'(hazard_stall), 32'(haz));
      chk({tag, ".ready"}, 32'(id_ready), 32'(rdy));
      chk({tag, ".s_hazard"}, 32'(s_hazard_stall), 32'(haz));
      chk({tag, ".s_ready"}, 32'(s_id_ready), 32'(rdy));
   endtask

   task automatic tick_check(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".valid"}, 32'(out_valid), 32'(e.v));
         chk({tag, ".a"}, out_a, e.a);
         chk({tag, ".b"}, out_b, e.b);
         chk({tag, ".imm"}, out_immed, e.imm);
         chk({tag, ".wr"}, 32'(out_wr_addr), 32'(e.wr));
         chk({tag, ".op"}, 32'(out_opcode), 32'(e.op));
         chk({tag, ".cnt"}, 32'(stall_count), 32'(e.cnt));
         chk({tag, ".s_valid"}, 32'(s_out_valid), 32'(e.v));
         chk({tag, ".s_a"}, s_out_a, e.a);
         chk({tag, ".s_b"}, s_out_b, e.b);
         chk({tag, ".s_imm"}, s_out_immed, e.imm);
         chk({tag, ".s_wr"}, 32'(s_out_wr_addr), 32'(e.wr));
         chk({tag, ".s_op"}, 32'(s_out_opcode), 32'(e.op));
         chk({tag, ".s_cnt"}, 32'(s_stall_count), 32'(e.cnts));
         last = e;
      end
   endtask

   initial begin
      cnt_m = '0;
      cnt_s = '0;
      last  = '0;

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1; in_valid = 1'($urandom); instr = $urandom; stall_in = 1'($urandom);
         flush = 1'($urandom); wb_en = 1'($urandom); wb_addr = 5'($urandom);
         wb_data = $urandom; ex_is_load = 1'($urandom); ex_rd = 5'($urandom);
         expect_reset();
         tick_check("rst");
      end

      idle(); in_valid = 1'b1;
      instr = itype(6'h30, 5'd5, 5'd0, 16'h0000);
      expect_load(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 6'h30);
      tick_check("rd_r5");

      // Same-cycle writeback bypass
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
      instr = itype(6'h30, 5'd3, 5'd4, 16'h0005);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'h5, 5'd4, 6'h30);
      tick_check("bypass");

      wb_addr = 5'd0; wb_data = 32'h12345678;
      instr = rtype(5'd0, 5'd3, 5'd0);
      expect_load(1'b1, 32'h0, 32'h0, 32'h0, 5'd3, 6'h20);
      tick_check("r0_wr");

      wb_en = 1'b0;
      instr = rtype(5'd3, 5'd5, 5'd0);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 6'h20);
      tick_check("r0_rd");

      instr = rtype(5'd0, 5'd0, 5'd3);
      expect_load(1'b1, 32'h0, 32'hDEADBEEF, 32'h1800, 5'd0, 6'h20);
      tick_check("rtype_b");

      // Immediates, imm = 0x8001
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFEF00D;
      instr = itype(6'h3F, 5'd3, 5'd0, 16'h8001);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'hFFFE0004, 5'd0, 6'h3F);
      tick_check("imm_ff");

      wb_en = 1'b0;
      instr = itype(6'h39, 5'd3, 5'd0, 16'h8001);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'h80010000, 5'd0, 6'h39);
      tick_check("imm_lui");

      instr = itype(6'h32, 5'd3, 5'd0, 16'h8001);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'h00008001, 5'd0, 6'h32);
      tick_check("imm_ori");

      instr = itype(6'h01, 5'd3, 5'd0, 16'h8001);
      expect_load(1'b1, 32'hDEADBEEF, 32'h0, 32'hFFFE0004, 5'd0, 6'h01);
      tick_check("imm_br");

      instr = itype(6'h30, 5'd3, 5'd9, 16'h8001);
      expect_load(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'hFFFF8001, 5'd9, 6'h30);
      tick_check("imm_addi");

      // Load-use hazards
      ex_is_load = 1'b1; ex_rd = 5'd7;
      instr = itype(6'h30, 5'd1, 5'd7, 16'h0004);
      comb_chk("ld_use", 1'b1, 1'b0);
      expect_hold(1'b0, 1'b1);
      tick_check("ld_use");

      ex_rd = 5'd0;
      instr = itype(6'h30, 5'd0, 5'd0, 16'h0010);
      comb_chk("ld_rd0", 1'b0, 1'b1);
      expect_load(1'b1, 32'h0, 32'h0, 32'h10, 5'd0, 6'h30);
      tick_check("ld_rd0");

      ex_rd = 5'd8;
      instr = rtype(5'd1, 5'd2, 5'd8);
      comb_chk("ld_rtype", 1'b1, 1'b0);
      expect_hold(1'b0, 1'b1);
      tick_check("ld_rtype");

      in_valid = 1'b0;
      comb_chk("nv", 1'b0, 1'b1);
      expect_load(1'b0, 32'h0, 32'h0, 32'h4000, 5'd2, 6'h20);
      tick_check("nv_load");

      // Stall then flush with a coincident hazard
      in_valid = 1'b1; ex_is_load = 1'b0;
      instr = itype(6'h30, 5'd3, 5'd9, 16'h0002);
      expect_load(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h2, 5'd9, 6'h30);
      tick_check("pre_stall");

      stall_in = 1'b1;
      instr = itype(6'h39, 5'd9, 5'd9, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         wb_en = (i == 0); wb_addr = 5'd12; wb_data = 32'h00000ABC;
         comb_chk("stall", 1'b0, 1'b0);
         expect_hold(1'b1, 1'b0);
         tick_check("stall");
      end

      stall_in = 1'b0; flush = 1'b1; wb_en = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd3;
      instr = itype(6'h30, 5'd3, 5'd0, 16'h0000);
      comb_chk("flush_haz", 1'b1, 1'b0);
      expect_hold(1'b0, 1'b0);
      tick_check("flush_haz");

      flush = 1'b0; ex_is_load = 1'b0;
      instr = itype(6'h30, 5'd12, 5'd0, 16'h0000);
      expect_load(1'b1, 32'h00000ABC, 32'h0, 32'h0, 5'd0, 6'h30);
      tick_check("wb_stall");

      // Consecutive hazards saturate the 2-bit counter
      ex_is_load = 1'b1; ex_rd = 5'd4;
      instr = itype(6'h30, 5'd4, 5'd0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         expect_hold(1'b0, 1'b1);
         tick_check("sat");
      end

      // Reset during a stall
      stall_in = 1'b1; rst = 1'b1;
      expect_reset();
      tick_check("rst_mid");

      rst = 1'b0; stall_in = 1'b0; ex_is_load = 1'b0;
      instr = itype(6'h30, 5'd12, 5'd0, 16'h0000);
      expect_load(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 6'h30);
      tick_check("rd_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
